fcmp_stage: RTL and testbench

- Pipelined floating-point compare/min-max execution stage in the FPU.
- Takes operand pairs from the issue logic, performs the single-precision less-than/equal ordering, and returns an integer or float result to writeback.
- Uses valid/ready handshakes on both sides.
- Two register stages; sustains one operation per cycle when not back-pressured.

---
 rtl/fcmp_stage.sv | 109 ++++++++++
 tb/tb_fcmp_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_stage.sv
// fcmp_stage: two-stage single-precision compare / min-max unit with valid-ready handshakes
module fcmp_stage #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] NEG_ZERO = 32'h80000000;
  logic             s1_valid, s2_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x1, s1_x2;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_nan1, s1_nan2, s1_zero1, s1_zero2;
  logic             s1_adv, s2_adv, accept;
  logic             nan_any, both_zero, mag_lt, mag_gt, lt_raw, lt, eq, illegal;
  logic [31:0]      min_v, max_v, result;
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;
  // Ordering on the registered operands; +0/-0 collapse to equal and any NaN kills the relation
  always_comb begin
    nan_any   = s1_nan1 || s1_nan2;
    both_zero = s1_zero1 && s1_zero2;
    mag_lt    = s1_x1[30:0] < s1_x2[30:0];
    mag_gt    = s1_x1[30:0] > s1_x2[30:0];
    lt_raw    = both_zero ? 1'b0 :
                (s1_x1[31] != s1_x2[31]) ? s1_x1[31] :
                s1_x1[31] ? mag_gt : mag_lt;
    lt        = !nan_any && lt_raw;
    eq        = !nan_any && (both_zero || s1_x1 == s1_x2);
    min_v     = (s1_nan1 && s1_nan2) ? QNAN :
                s1_nan1 ? s1_x2 :
                s1_nan2 ? s1_x1 :
                both_zero ? NEG_ZERO :
                lt ? s1_x1 : s1_x2;
    max_v     = (s1_nan1 && s1_nan2) ? QNAN :
                s1_nan1 ? s1_x2 :
                s1_nan2 ? s1_x1 :
                both_zero ? 32'h0 :
                lt ? s1_x2 : s1_x1;
    illegal   = s1_op > 3'd4;
    result    = (s1_op == 3'd0) ? {31'h0, eq} :
                (s1_op == 3'd1) ? {31'h0, lt} :
                (s1_op == 3'd2) ? {31'h0, lt || eq} :
                (s1_op == 3'd3) ? min_v :
                (s1_op == 3'd4) ? max_v : 32'h0;
  end
  // S1: capture operands, op, tag and classify flags on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_tag   <= '0;
      s1_nan1  <= 1'b0;
      s1_nan2  <= 1'b0;
      s1_zero1 <= 1'b0;
      s1_zero2 <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op    <= in_op;
        s1_x1    <= in_x1;
        s1_x2    <= in_x2;
        s1_tag   <= in_tag;
        s1_nan1  <= (in_x1[30:23] == 8'hFF) && (in_x1[22:0] != 23'h0);
        s1_nan2  <= (in_x2[30:23] == 8'hFF) && (in_x2[22:0] != 23'h0);
        s1_zero1 <= in_x1[30:0] == 31'h0;
        s1_zero2 <= in_x2[30:0] == 31'h0;
      end
    end
  end
  // S2: register the result and hold it until writeback takes it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid    <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= result;
        out_tag     <= s1_tag;
        out_illegal <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_fcmp_stage.sv
// tb_fcmp_stage: scoreboard bench for fcmp_stage with a real-valued reference model
module tb_fcmp_stage;
  localparam int TAG_W = 6;
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [31:0]      in_x1 = '0;
  logic [31:0]      in_x2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  typedef struct packed {
    logic             i;
    logic [TAG_W-1:0] t;
    logic [31:0]      d;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit stall_seen = 0;
  bit rnd_ready = 0;
  fcmp_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  endfunction
  function automatic real to_real(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'hFF) m = 1.0e300;
    else if (b[30:23] == 8'h00) m = real'(b[22:0]) * 2.0 ** (-149.0);
    else m = (real'(b[22:0]) + 8388608.0) * 2.0 ** (real'(int'(b[30:23]) - 150));
    return b[31] ? -m : m;
  endfunction
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    exp_t e;
    real ra, rb;
    bit na, nb;
    na = is_nan(a);
    nb = is_nan(b);
    ra = to_real(a);
    rb = to_real(b);
    e.t = t;
    e.i = 1'b0;
    e.d = 32'h0;
    if (op == 3'd0) e.d = {31'h0, !(na || nb) && ra == rb};
    else if (op == 3'd1) e.d = {31'h0, !(na || nb) && ra < rb};
    else if (op == 3'd2) e.d = {31'h0, !(na || nb) && ra <= rb};
    else if (op == 3'd3 || op == 3'd4) begin
      if (na && nb) e.d = 32'h7FC00000;
      else if (na) e.d = b;
      else if (nb) e.d = a;
      else if (ra == 0.0 && rb == 0.0) e.d = (op == 3'd3) ? 32'h80000000 : 32'h0;
      else if (op == 3'd3) e.d = (ra < rb) ? a : b;
      else e.d = (ra < rb) ? b : a;
    end else e.i = 1'b1;
    return e;
  endfunction
  function automatic logic [31:0] rand_val(input bit nan_ok);
    logic [31:0] v;
    int c;
    v = $urandom;
    c = $urandom_range(0, 7);
    if (c == 0) v[30:0] = '0;
    else if (c == 1) begin v[30:23] = 8'hFF; v[22:0] = '0; end
    else if (c == 2) v[30:23] = 8'h00;
    else if (c == 3 && nan_ok) begin v[30:23] = 8'hFF; v[0] = 1'b1; end
    else if (c == 4) v[30:20] = {8'h7F, 3'b000};
    if (!nan_ok && is_nan(v)) v[30:23] = 8'h7F;
    return v;
  endfunction
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_op = op;
    in_x1 = a;
    in_x2 = b;
    in_tag = t;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        q.push_back(model(op, a, b, t));
      end else stall_seen = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for tag %h", t);
    end
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  logic [31:0] pd;
  logic [TAG_W-1:0] pt;
  logic pi;
  bit held = 0;
  // Monitor: pop and compare on each output transfer, verify stall stability, drop killed ops on flush
  always @(negedge clk) begin
    if (!rstn) held = 0;
    else begin
      if (held) check("stall_hold", {out_valid, out_illegal, out_tag, out_data}, {1'b1, pi, pt, pd});
      held = out_valid && !out_ready && !flush;
      pd = out_data;
      pt = out_tag;
      pi = out_illegal;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got tag %h data %h with nothing expected", out_tag, out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", {out_illegal, out_tag, out_data}, {e.i, e.t, e.d});
        end
      end
      if (flush) q.delete();
    end
  end
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", {out_valid, out_illegal, out_tag, out_data}, 64'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(3'd1, 32'hBF800000, 32'h3F800000, 6'd5);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_s1", out_valid, 0);
    @(negedge clk);
    check("latency_s2", out_valid, 1);
    @(posedge clk);
    #1;
    send(3'd1, 32'h3F800000, 32'hBF800000, 6'd6);
    send(3'd0, 32'h00000000, 32'h80000000, 6'd7);
    send(3'd2, 32'h00000000, 32'h80000000, 6'd8);
    send(3'd1, 32'h00000000, 32'h80000000, 6'd9);
    send(3'd3, 32'h00000000, 32'h80000000, 6'd10);
    send(3'd4, 32'h00000000, 32'h80000000, 6'd11);
    send(3'd3, 32'h80000000, 32'h00000000, 6'd12);
    send(3'd4, 32'h80000000, 32'h00000000, 6'd13);
    send(3'd4, 32'h7FC00001, 32'h40000000, 6'd14);
    send(3'd3, 32'h40000000, 32'hFF800001, 6'd15);
    send(3'd4, 32'h7FC00001, 32'hFFC00000, 6'd16);
    send(3'd1, 32'h7FC00001, 32'h40000000, 6'd17);
    send(3'd1, 32'h40000000, 32'h7F800001, 6'd18);
    send(3'd6, 32'h3F800000, 32'h40000000, 6'd19);
    send(3'd1, 32'h00000001, 32'h00000002, 6'd20);
    send(3'd1, 32'h80000002, 32'h80000001, 6'd21);
    send(3'd1, 32'h7F7FFFFF, 32'h7F800000, 6'd22);
    send(3'd2, 32'hFF800000, 32'hFF800000, 6'd23);
    idle(4);
    stall_seen = 0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      for (int i = 0; i < 8; i++) send(3'd1, rand_val(0), rand_val(0), TAG_W'(i));
    join
    idle(4);
    check("stall_in_ready_drop", stall_seen, 1);
    out_ready = 1'b0;
    send(3'd1, 32'hBF800000, 32'h3F800000, 6'd40);
    send(3'd0, 32'h3F800000, 32'h3F800000, 6'd41);
    in_op = 3'd2;
    in_tag = 6'd42;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd4, 32'hC0000000, 32'h3F800000, 6'd43);
    idle(4);
    rnd_ready = 1;
    for (int i = 0; i < 500; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = rand_val(op >= 3'd3);
      b = $urandom_range(0, 1) ? a : rand_val(op >= 3'd3);
      send(op, a, b, TAG_W'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(1);
    rnd_ready = 0;
    #2;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
